// File: rtl/qspi_flash_responder.sv
// ---------------------------------------------------------------------------
// qspi_flash_responder
//   Flash-side QSPI target. SCLK, CS_N and IO are oversampled on h_clk, the
//   opcode is decoded and the address is collected. Reads are then served from
//   a 32-bit word memory port and writes are accepted into it. Data moves on
//   IO1 (single-line ops) or IO3..IO0 (quad ops). SPI mode 0 is used: inputs
//   are captured on SCLK rise and outputs change on SCLK fall.
//
// Ports
//   h_clk, h_rstn    system clock / synchronous active-low reset
//   qspi_sclk_in     SCLK from the controller (CPOL=0), asynchronous to h_clk
//   qspi_cs_n_in     chip select, active-low
//   qspi_io_in       IO3..IO0 pin values
//   qspi_io_out      IO3..IO0 drive values
//   qspi_io_oe       per-line output enable (1 = drive)
//   mem_addr_out     word address for memory reads and writes
//   mem_rd_en_out    1-cycle read strobe; mem_rdata_in is valid one h_clk later
//   mem_rdata_in     read data
//   mem_wr_en_out    1-cycle write strobe, qualifies mem_wdata_out
//   mem_wdata_out    write data
//   addr4_mode_out   sticky 4-byte-address mode (set by B7h, cleared by E9h)
//   cmd_err_out      1-cycle pulse on an unsupported opcode
// ---------------------------------------------------------------------------
module qspi_flash_responder #(
   parameter int ADDR_W       = 24,
   parameter int DUMMY_CYCLES = 0
) (
   input  logic              h_clk,
   input  logic              h_rstn,
   input  logic              qspi_sclk_in,
   input  logic              qspi_cs_n_in,
   input  logic [3:0]        qspi_io_in,
   output logic [3:0]        qspi_io_out,
   output logic [3:0]        qspi_io_oe,
   output logic [ADDR_W-1:0] mem_addr_out,
   output logic              mem_rd_en_out,
   input  logic [31:0]       mem_rdata_in,
   output logic              mem_wr_en_out,
   output logic [31:0]       mem_wdata_out,
   output logic              addr4_mode_out,
   output logic              cmd_err_out
);

   typedef enum logic [2:0] {
      S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_RD_DATA, S_WR_DATA, S_IGNORE
   } state_t;

   state_t r_state, w_next_state;

   // Pin synchronisers and SCLK edge detection
   logic       r_sclk_meta, r_sclk_sync, r_sclk_prev;
   logic       r_cs_meta, r_cs_sync;
   logic [3:0] r_io_meta, r_io_sync;
   logic       w_sclk_rise, w_sclk_fall, w_cs_high;

   // Datapath state
   logic [5:0]        r_bit_cnt;
   logic [31:0]       r_shift;
   logic [31:0]       r_rd_shift;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_wdata;
   logic [3:0]        r_io_out, r_io_oe;
   logic              r_mem_rd_en, r_mem_wr_en, r_rd_pend;
   logic              r_addr4_mode, r_cmd_err;
   logic              r_quad, r_4b, r_read, r_dummy;

   // Decode / shift helpers
   logic [31:0] w_shift_1, w_shift_4, w_shift_next;
   logic [7:0]  w_opcode;
   logic        w_dec_known, w_dec_rw, w_dec_read, w_dec_quad, w_dec_4b;
   logic        w_dec_dummy, w_dec_set4, w_dec_clr4;
   logic [5:0]  w_addr_last, w_data_last, w_dummy_last;
   logic        w_use_dummy;
   logic        w_unused;

   always_ff @(posedge h_clk) begin
      if (!h_rstn) begin
         r_sclk_meta <= 1'b0;
         r_sclk_sync <= 1'b0;
         r_sclk_prev <= 1'b0;
         r_cs_meta   <= 1'b1;
         r_cs_sync   <= 1'b1;
         r_io_meta   <= '0;
         r_io_sync   <= '0;
      end else begin
         // NOTE: non-blocking assignments so each stage samples its pre-edge
         // input, giving a real two-flop chain instead of a single wire.
         r_sclk_meta <= qspi_sclk_in;
         r_sclk_sync <= r_sclk_meta;
         r_sclk_prev <= r_sclk_sync;
         r_cs_meta   <= qspi_cs_n_in;
         r_cs_sync   <= r_cs_meta;
         r_io_meta   <= qspi_io_in;
         r_io_sync   <= r_io_meta;
      end
   end

   assign w_sclk_rise = r_sclk_sync & ~r_sclk_prev;
   assign w_sclk_fall = ~r_sclk_sync & r_sclk_prev;
   assign w_cs_high   = r_cs_sync;

   assign w_shift_1    = {r_shift[30:0], r_io_sync[0]};
   assign w_shift_4    = {r_shift[27:0], r_io_sync};
   assign w_shift_next = r_quad ? w_shift_4 : w_shift_1;
   assign w_opcode     = w_shift_1[7:0];

   assign w_addr_last  = r_quad ? (r_4b ? 6'd7 : 6'd5) : (r_4b ? 6'd31 : 6'd23);
   assign w_data_last  = r_quad ? 6'd7 : 6'd31;
   assign w_use_dummy  = r_dummy && (DUMMY_CYCLES != 0);
   assign w_dummy_last = 6'(DUMMY_CYCLES - 1);

   // Byte-address bits [1:0] and bits above the word address are dropped.
   assign w_unused = ^{w_shift_next, r_shift[31]};

   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves
      // one unassigned, which would otherwise infer a latch.
      w_dec_known = 1'b1;
      w_dec_rw    = 1'b1;
      w_dec_read  = 1'b0;
      w_dec_quad  = 1'b0;
      w_dec_4b    = r_addr4_mode;
      w_dec_dummy = 1'b0;
      w_dec_set4  = 1'b0;
      w_dec_clr4  = 1'b0;
      case (w_opcode)
         8'h03: w_dec_read = 1'b1;
         8'hEB: begin w_dec_read = 1'b1; w_dec_quad = 1'b1; w_dec_dummy = 1'b1; end
         8'h02: ;
         8'h32: w_dec_quad = 1'b1;
         8'h13: begin w_dec_read = 1'b1; w_dec_4b = 1'b1; end
         8'hEC: begin
            w_dec_read = 1'b1; w_dec_quad = 1'b1; w_dec_4b = 1'b1; w_dec_dummy = 1'b1;
         end
         8'hB7: begin w_dec_rw = 1'b0; w_dec_set4 = 1'b1; end
         8'hE9: begin w_dec_rw = 1'b0; w_dec_clr4 = 1'b1; end
         default: begin w_dec_known = 1'b0; w_dec_rw = 1'b0; end
      endcase
   end

   always_ff @(posedge h_clk) begin
      if (!h_rstn) r_state <= S_IDLE;
      else         r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      if (w_cs_high) begin
         w_next_state = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: w_next_state = S_CMD;
            S_CMD:
               if (w_sclk_rise && r_bit_cnt == 6'd7)
                  w_next_state = w_dec_rw ? S_ADDR : S_IGNORE;
            S_ADDR:
               if (w_sclk_rise && r_bit_cnt == w_addr_last) begin
                  if (!r_read)          w_next_state = S_WR_DATA;
                  else if (w_use_dummy) w_next_state = S_DUMMY;
                  else                  w_next_state = S_RD_DATA;
               end
            S_DUMMY:
               if (w_sclk_rise && r_bit_cnt == w_dummy_last) w_next_state = S_RD_DATA;
            default: ;
         endcase
      end
   end

   always_ff @(posedge h_clk) begin
      if (!h_rstn) begin
         r_bit_cnt    <= '0;
         r_shift      <= '0;
         r_rd_shift   <= '0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_io_out     <= '0;
         r_io_oe      <= '0;
         r_mem_rd_en  <= 1'b0;
         r_mem_wr_en  <= 1'b0;
         r_rd_pend    <= 1'b0;
         r_addr4_mode <= 1'b0;
         r_cmd_err    <= 1'b0;
         r_quad       <= 1'b0;
         r_4b         <= 1'b0;
         r_read       <= 1'b0;
         r_dummy      <= 1'b0;
      end else begin
         r_mem_rd_en <= 1'b0;
         r_mem_wr_en <= 1'b0;
         r_cmd_err   <= 1'b0;
         r_rd_pend   <= r_mem_rd_en;
         // The write strobe used the current address; step on afterwards.
         if (r_mem_wr_en) r_addr <= r_addr + ADDR_W'(1);

         if (w_cs_high) begin
            // Frame over: drop partial words and any read still in flight.
            r_io_oe   <= '0;
            r_io_out  <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_rd_pend <= 1'b0;
            r_quad    <= 1'b0;
         end else begin
            case (r_state)
               S_CMD: if (w_sclk_rise) begin
                  r_shift   <= w_shift_1;
                  r_bit_cnt <= r_bit_cnt + 6'd1;
                  if (r_bit_cnt == 6'd7) begin
                     r_bit_cnt <= '0;
                     r_shift   <= '0;
                     r_read    <= w_dec_read;
                     r_quad    <= w_dec_quad;
                     r_4b      <= w_dec_4b;
                     r_dummy   <= w_dec_dummy;
                     r_cmd_err <= ~w_dec_known;
                     if (w_dec_set4) r_addr4_mode <= 1'b1;
                     if (w_dec_clr4) r_addr4_mode <= 1'b0;
                  end
               end
               S_ADDR: if (w_sclk_rise) begin
                  r_shift   <= w_shift_next;
                  r_bit_cnt <= r_bit_cnt + 6'd1;
                  if (r_bit_cnt == w_addr_last) begin
                     r_bit_cnt <= '0;
                     r_shift   <= '0;
                     r_addr    <= w_shift_next[ADDR_W+1:2];
                     if (r_read && !w_use_dummy) r_mem_rd_en <= 1'b1;
                  end
               end
               S_DUMMY: if (w_sclk_rise) begin
                  r_bit_cnt <= r_bit_cnt + 6'd1;
                  if (r_bit_cnt == w_dummy_last) begin
                     r_bit_cnt   <= '0;
                     r_mem_rd_en <= 1'b1;
                  end
               end
               S_RD_DATA: begin
                  if (r_rd_pend) begin
                     r_rd_shift <= mem_rdata_in;
                  end else if (w_sclk_fall) begin
                     if (r_quad) begin
                        r_io_out   <= r_rd_shift[31:28];
                        r_io_oe    <= 4'b1111;
                        r_rd_shift <= {r_rd_shift[27:0], 4'h0};
                     end else begin
                        r_io_out   <= {2'b00, r_rd_shift[31], 1'b0};
                        r_io_oe    <= 4'b0010;
                        r_rd_shift <= {r_rd_shift[30:0], 1'b0};
                     end
                     r_bit_cnt <= r_bit_cnt + 6'd1;
                     // Last bit of the word is on the pins: prefetch the next.
                     if (r_bit_cnt == w_data_last) begin
                        r_bit_cnt   <= '0;
                        r_addr      <= r_addr + ADDR_W'(1);
                        r_mem_rd_en <= 1'b1;
                     end
                  end
               end
               S_WR_DATA: if (w_sclk_rise) begin
                  r_shift   <= w_shift_next;
                  r_bit_cnt <= r_bit_cnt + 6'd1;
                  if (r_bit_cnt == w_data_last) begin
                     r_bit_cnt   <= '0;
                     r_shift     <= '0;
                     r_wdata     <= w_shift_next;
                     r_mem_wr_en <= 1'b1;
                  end
               end
               S_IGNORE: r_io_oe <= '0;
               default: begin
                  r_bit_cnt <= '0;
                  r_shift   <= '0;
                  r_quad    <= 1'b0;
               end
            endcase
         end
      end
   end

   assign qspi_io_out    = r_io_out;
   assign qspi_io_oe     = r_io_oe;
   assign mem_addr_out   = r_addr;
   assign mem_rd_en_out  = r_mem_rd_en;
   assign mem_wr_en_out  = r_mem_wr_en;
   assign mem_wdata_out  = r_wdata;
   assign addr4_mode_out = r_addr4_mode;
   assign cmd_err_out    = r_cmd_err;

endmodule
